// File: rtl/result_packer_if.sv
// Result packer bus bundle.
// Groups the packer-side signals so the engine/FIFO side and the packer share
// one connection point.
//   clear      : synchronous restart for a new layer (master -> slave)
//   in_valid   : engine halfword present               (master -> slave)
//   in_data    : engine halfword, HALF_W bits          (master -> slave)
//   in_last    : final halfword of the layer           (master -> slave)
//   in_ready   : packer accepts a halfword this cycle  (slave -> master)
//   fifo_full  : result FIFO full flag                 (master -> slave)
//   wr_en      : result FIFO write strobe              (slave -> master)
//   wr_data    : packed FIFO word, 2*HALF_W bits       (slave -> master)
//   word_count : words written since clear/reset       (slave -> master)
//   done       : sticky, last word of layer written    (slave -> master)
//   drop_err   : sticky, halfword offered while done   (slave -> master)
interface result_packer_if #(
  parameter int HALF_W = 16,
  parameter int CNT_W  = 16
);
  logic                  clear;
  logic                  in_valid;
  logic [HALF_W-1:0]     in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  fifo_full;
  logic                  wr_en;
  logic [2*HALF_W-1:0]   wr_data;
  logic [CNT_W-1:0]      word_count;
  logic                  done;
  logic                  drop_err;

  modport master (
    output clear, in_valid, in_data, in_last, fifo_full,
    input  in_ready, wr_en, wr_data, word_count, done, drop_err
  );

  modport slave (
    input  clear, in_valid, in_data, in_last, fifo_full,
    output in_ready, wr_en, wr_data, word_count, done, drop_err
  );
endinterface

// File: rtl/result_packer.sv
// Result packer.
// Pairs engine result halfwords into full FIFO words (first halfword in the
// low half), pads a trailing odd halfword with PAD_VALUE, writes one word per
// wr_en pulse, counts written words (saturating) and flags end of layer.
// Ports:
//   clk : engine clock
//   rst : asynchronous, active-low reset
//   bus : result_packer_if.slave (stream input, FIFO write side, status)
module result_packer #(
  parameter int                HALF_W    = 16,
  parameter int                CNT_W     = 16,
  parameter logic [HALF_W-1:0] PAD_VALUE = {HALF_W{1'b0}}
) (
  input logic            clk,
  input logic            rst,
  result_packer_if.slave bus
);
  localparam int WORD_W = 2 * HALF_W;

  logic [HALF_W-1:0] low_q, low_d;
  logic              have_low_q, have_low_d;
  logic              low_last_q, low_last_d;
  logic [WORD_W-1:0] pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_last_q, pend_last_d;
  logic              wr_en_q, wr_en_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              done_q, done_d;
  logic              drop_err_q, drop_err_d;

  logic in_ready;
  logic accept;
  logic drain;
  logic slot_free;

  // Stall only when both the low-half holder and the pending word are busy,
  // so a full FIFO still lets one more low half in.
  assign in_ready  = !done_q && !(have_low_q && pend_valid_q);
  assign accept    = bus.in_valid && in_ready;
  assign drain     = pend_valid_q && !bus.fifo_full;
  // The pending slot can take a new word if empty or emptying on this edge.
  assign slot_free = !pend_valid_q || drain;

  // Next-state logic: drain the pending word, absorb the incoming halfword,
  // update sticky flags, and let clear override everything.
  always_comb begin
    low_d        = low_q;
    have_low_d   = have_low_q;
    low_last_d   = low_last_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    pend_last_d  = pend_last_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    count_d      = count_q;
    done_d       = done_q;
    drop_err_d   = drop_err_q;

    if (drain) begin
      wr_en_d      = 1'b1;
      wr_data_d    = pend_q;
      pend_valid_d = 1'b0;
      if (count_q != {CNT_W{1'b1}}) begin
        count_d = count_q + CNT_W'(1);
      end
      if (pend_last_q) begin
        done_d = 1'b1;
      end
    end

    // A final odd halfword arriving while the pending word is stuck behind a
    // full FIFO is parked in the low holder and padded once the slot frees.
    if (accept) begin
      if (have_low_q) begin
        pend_d       = {bus.in_data, low_q};
        pend_valid_d = 1'b1;
        pend_last_d  = bus.in_last;
        have_low_d   = 1'b0;
        low_last_d   = 1'b0;
      end else if (bus.in_last && slot_free) begin
        pend_d       = {PAD_VALUE, bus.in_data};
        pend_valid_d = 1'b1;
        pend_last_d  = 1'b1;
      end else begin
        low_d      = bus.in_data;
        have_low_d = 1'b1;
        low_last_d = bus.in_last;
      end
    end else if (have_low_q && low_last_q && slot_free) begin
      pend_d       = {PAD_VALUE, low_q};
      pend_valid_d = 1'b1;
      pend_last_d  = 1'b1;
      have_low_d   = 1'b0;
      low_last_d   = 1'b0;
    end

    if (bus.in_valid && done_q) begin
      drop_err_d = 1'b1;
    end

    if (bus.clear) begin
      low_d        = '0;
      have_low_d   = 1'b0;
      low_last_d   = 1'b0;
      pend_d       = '0;
      pend_valid_d = 1'b0;
      pend_last_d  = 1'b0;
      wr_en_d      = 1'b0;
      wr_data_d    = wr_data_q;
      count_d      = '0;
      done_d       = 1'b0;
      drop_err_d   = 1'b0;
    end
  end

  // State registers; reset drops any held half or pending word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      low_q        <= '0;
      have_low_q   <= 1'b0;
      low_last_q   <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_last_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      low_q        <= low_d;
      have_low_q   <= have_low_d;
      low_last_q   <= low_last_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      pend_last_q  <= pend_last_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      count_q      <= count_d;
      done_q       <= done_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.word_count = count_q;
  assign bus.done       = done_q;
  assign bus.drop_err   = drop_err_q;
endmodule

// File: tb/tb_result_packer.sv
// Testbench for result_packer.
// Drives a default-width packer and a CNT_W=4 packer from two interface
// instances; expected words come from the pairing/padding rule applied to the
// halfword stream the bench itself sends.
module tb_result_packer;
  localparam logic [15:0] PAD = 16'h0000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  result_packer_if #(.HALF_W(16), .CNT_W(16)) bus ();
  result_packer_if #(.HALF_W(16), .CNT_W(4))  bus4 ();

  result_packer #(.HALF_W(16), .CNT_W(16), .PAD_VALUE(PAD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  result_packer #(.HALF_W(16), .CNT_W(4), .PAD_VALUE(PAD)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    int               n;
    logic [3:0][15:0] h;
    logic [1:0][31:0] w;
    int               nw;
  } frame_t;

  frame_t vecs[4];

  // One comparison: bumps the counters and reports any disagreement.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
  endtask

  // Drives every input of the main packer in one go.
  task automatic applyStimulus(input logic valid, input logic [15:0] data,
                               input logic last, input logic full, input logic clr);
    bus.in_valid  = valid;
    bus.in_data   = data;
    bus.in_last   = last;
    bus.fifo_full = full;
    bus.clear     = clr;
  endtask

  // One-cycle clear of the main packer, returning on the following negedge.
  task automatic clearMain();
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends lo then hi (hi marked last) with handshaking and returns the first
  // word written, within a bounded number of cycles.
  task automatic sendPair(input logic [15:0] lo, input logic [15:0] hi,
                          output logic [31:0] word, output int nWr);
    int   sent = 0;
    logic acc;
    nWr  = 0;
    word = '0;
    for (int c = 0; c < 20 && nWr == 0; c++) begin
      if (sent < 2) applyStimulus(1'b1, (sent == 0) ? lo : hi, sent == 1, 1'b0, 1'b0);
      else          applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      acc = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (acc) sent++;
      if (bus.wr_en) begin
        word = bus.wr_data;
        nWr++;
      end
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] got[4];
    int          gotEdge[4];
    logic        gotDone[4];
    int          gotN;
    int          ci;
    logic [31:0] word;
    int          nWr;
    logic [15:0] src[64];
    logic [31:0] expW[32];
    int          n, nExp, srcIdx, wrIdx, cyc, extra, pulses;
    logic        valid, full, accepted;

    vecs[0].n = 4; vecs[0].h = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    vecs[0].w = {32'h0004_0003, 32'h0002_0001}; vecs[0].nw = 2;
    vecs[1].n = 3; vecs[1].h = {16'h0000, 16'h0033, 16'h0022, 16'h0011};
    vecs[1].w = {32'h0000_0033, 32'h0022_0011}; vecs[1].nw = 2;
    vecs[2].n = 1; vecs[2].h = {16'h0000, 16'h0000, 16'h0000, 16'hABCD};
    vecs[2].w = {32'h0000_0000, 32'h0000_ABCD}; vecs[2].nw = 1;
    vecs[3].n = 2; vecs[3].h = {16'h0000, 16'h0000, 16'h8000, 16'hFFFF};
    vecs[3].w = {32'h0000_0000, 32'h8000_FFFF}; vecs[3].nw = 1;

    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    bus4.clear = 1'b0; bus4.in_valid = 1'b0; bus4.in_data = '0;
    bus4.in_last = 1'b0; bus4.fifo_full = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_wr_en",      bus.wr_en, 0);
    checkOutput("rst_wr_data",    bus.wr_data, 0);
    checkOutput("rst_word_count", bus.word_count, 0);
    checkOutput("rst_done",       bus.done, 0);
    checkOutput("rst_drop_err",   bus.drop_err, 0);
    checkOutput("rst_in_ready",   bus.in_ready, 1);
    rst = 1'b1;
    @(negedge clk);

    // Table frames, back-to-back with the FIFO never full.
    for (int v = 0; v < 4; v++) begin
      clearMain();
      gotN = 0;
      for (int c = 0; c <= vecs[v].n + 3; c++) begin
        if (c > 0 && bus.wr_en) begin
          if (gotN < 4) begin
            got[gotN] = bus.wr_data; gotEdge[gotN] = c; gotDone[gotN] = bus.done;
          end
          gotN++;
        end
        if (c < vecs[v].n) begin
          checkOutput($sformatf("vec%0d_ready%0d", v, c), bus.in_ready, 1);
          applyStimulus(1'b1, vecs[v].h[c], c == vecs[v].n - 1, 1'b0, 1'b0);
        end else begin
          applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
      end
      checkOutput($sformatf("vec%0d_nwords", v), gotN, vecs[v].nw);
      for (int k = 0; k < vecs[v].nw && k < gotN; k++) begin
        ci = (2 * k + 1 < vecs[v].n) ? 2 * k + 1 : vecs[v].n - 1;
        checkOutput($sformatf("vec%0d_word%0d", v, k), got[k], vecs[v].w[k]);
        checkOutput($sformatf("vec%0d_edge%0d", v, k), gotEdge[k], ci + 2);
        checkOutput($sformatf("vec%0d_done%0d", v, k), gotDone[k], k == vecs[v].nw - 1);
      end
      checkOutput($sformatf("vec%0d_count", v), bus.word_count, vecs[v].nw);
      checkOutput($sformatf("vec%0d_done", v), bus.done, 1);
      checkOutput($sformatf("vec%0d_ready_done", v), bus.in_ready, 0);
    end

    // FIFO full for five edges right after a pair completes.
    clearMain();
    applyStimulus(1'b1, 16'h0101, 1'b0, 1'b0, 1'b0); @(negedge clk);
    applyStimulus(1'b1, 16'h0202, 1'b0, 1'b0, 1'b0); @(negedge clk);
    applyStimulus(1'b1, 16'h0303, 1'b0, 1'b1, 1'b0); @(negedge clk);
    applyStimulus(1'b1, 16'h0404, 1'b1, 1'b1, 1'b0);
    for (int c = 3; c <= 7; c++) begin
      checkOutput($sformatf("stall_wr_en%0d", c), bus.wr_en, 0);
      checkOutput($sformatf("stall_ready%0d", c), bus.in_ready, 0);
      if (c == 7) bus.fifo_full = 1'b0;
      @(negedge clk);
    end
    checkOutput("stall_release_wr_en", bus.wr_en, 1);
    checkOutput("stall_release_data",  bus.wr_data, 32'h0202_0101);
    checkOutput("stall_release_ready", bus.in_ready, 1);
    checkOutput("stall_release_done",  bus.done, 0);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_gap_wr_en", bus.wr_en, 0);
    @(negedge clk);
    checkOutput("stall_second_wr_en", bus.wr_en, 1);
    checkOutput("stall_second_data",  bus.wr_data, 32'h0404_0303);
    checkOutput("stall_second_done",  bus.done, 1);
    checkOutput("stall_second_count", bus.word_count, 2);

    // Reset between the two halves of a pair.
    clearMain();
    applyStimulus(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("midrst_wr_en",    bus.wr_en, 0);
    checkOutput("midrst_wr_data",  bus.wr_data, 0);
    checkOutput("midrst_count",    bus.word_count, 0);
    checkOutput("midrst_done",     bus.done, 0);
    checkOutput("midrst_drop_err", bus.drop_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    checkOutput("midrst_ready", bus.in_ready, 1);
    sendPair(16'h00BB, 16'h00CC, word, nWr);
    checkOutput("midrst_nwr",   nWr, 1);
    checkOutput("midrst_word",  word, 32'h00CC_00BB);
    checkOutput("midrst_done1", bus.done, 1);
    checkOutput("midrst_cnt1",  bus.word_count, 1);

    // Offer after done, then clear with in_valid still high.
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("drop_err_set", bus.drop_err, 1);
    checkOutput("drop_wr_en",   bus.wr_en, 0);
    checkOutput("drop_ready",   bus.in_ready, 0);
    checkOutput("drop_done",    bus.done, 1);
    @(negedge clk);
    checkOutput("drop_wr_en2",  bus.wr_en, 0);
    checkOutput("drop_count",   bus.word_count, 1);
    applyStimulus(1'b1, 16'h5678, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("clr_done",     bus.done, 0);
    checkOutput("clr_drop_err", bus.drop_err, 0);
    checkOutput("clr_count",    bus.word_count, 0);
    checkOutput("clr_ready",    bus.in_ready, 1);
    checkOutput("clr_wr_en",    bus.wr_en, 0);
    sendPair(16'h0A0A, 16'h0B0B, word, nWr);
    checkOutput("clr_next_nwr",  nWr, 1);
    checkOutput("clr_next_word", word, 32'h0B0B_0A0A);

    // Random frames with random source gaps and FIFO back-pressure.
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) src[i] = 16'($urandom());
      nExp = (n + 1) / 2;
      for (int i = 0; i < n; i += 2)
        expW[i / 2] = (i + 1 < n) ? {src[i + 1], src[i]} : {PAD, src[i]};
      clearMain();
      srcIdx = 0; wrIdx = 0; cyc = 0;
      while ((srcIdx < n || wrIdx < nExp) && cyc < 2000) begin
        full  = ($urandom_range(0, 3) == 0);
        valid = (srcIdx < n) && ($urandom_range(0, 3) != 0);
        applyStimulus(valid, valid ? src[srcIdx] : 16'h0, valid && (srcIdx == n - 1), full, 1'b0);
        accepted = valid && bus.in_ready;
        @(negedge clk);
        cyc++;
        if (accepted) srcIdx++;
        if (bus.wr_en) begin
          checkOutput($sformatf("rnd%0d_full_gate", f), full, 0);
          if (wrIdx < nExp) begin
            checkOutput($sformatf("rnd%0d_word%0d", f, wrIdx), bus.wr_data, expW[wrIdx]);
            checkOutput($sformatf("rnd%0d_done%0d", f, wrIdx), bus.done, wrIdx == nExp - 1);
          end else begin
            checkOutput($sformatf("rnd%0d_extra", f), wrIdx + 1, nExp);
          end
          wrIdx++;
        end
      end
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("rnd%0d_sent", f), srcIdx, n);
      checkOutput($sformatf("rnd%0d_written", f), wrIdx, nExp);
      extra = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (bus.wr_en) extra++;
      end
      checkOutput($sformatf("rnd%0d_idle_wr", f), extra, 0);
      checkOutput($sformatf("rnd%0d_final_done", f), bus.done, 1);
      checkOutput($sformatf("rnd%0d_final_count", f), bus.word_count, nExp);
    end

    // Narrow counter: 17 words must leave word_count parked at 15.
    srcIdx = 0; pulses = 0; cyc = 0;
    while (pulses < 17 && cyc < 200) begin
      bus4.in_valid  = (srcIdx < 34);
      bus4.in_data   = 16'(srcIdx);
      bus4.in_last   = (srcIdx == 33);
      bus4.fifo_full = 1'b0;
      accepted = bus4.in_valid && bus4.in_ready;
      @(negedge clk);
      cyc++;
      if (accepted) srcIdx++;
      if (bus4.wr_en) begin
        pulses++;
        checkOutput($sformatf("sat_count%0d", pulses), bus4.word_count, (pulses > 15) ? 15 : pulses);
      end
    end
    bus4.in_valid = 1'b0;
    checkOutput("sat_pulses", pulses, 17);
    @(negedge clk);
    checkOutput("sat_final", bus4.word_count, 15);
    checkOutput("sat_done",  bus4.done, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
